// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the hazard control unit: register width,
// FSM state encoding, shadow pipeline entry and the match helper.
package hazard_control_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hcu_state_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  wr;
    logic                  is_load;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_BUBBLE = '0;

  // A producer matches a source only if it really writes it; $0 is never a hit.
  function automatic logic entry_matches(input shadow_entry_t e,
                                         input logic [REG_ADDR_W-1:0] r);
    return e.valid & e.wr & (e.dest == r) & (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_control_unit_shadow_pipe.sv
// Three-slot shadow of in-flight destinations (IX, MEM, WB); a bubble is
// inserted into the IX slot whenever the decode slot is stalled or flushed.
module hazard_shadow_pipe
  import hazard_control_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          bubble,
  input  shadow_entry_t dec_entry,
  output shadow_entry_t s_ix,
  output shadow_entry_t s_mem,
  output shadow_entry_t s_wb
);

  shadow_entry_t s_ix_reg, s_mem_reg, s_wb_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ix_reg  <= SHADOW_BUBBLE;
      s_mem_reg <= SHADOW_BUBBLE;
      s_wb_reg  <= SHADOW_BUBBLE;
    end else begin
      s_wb_reg  <= s_mem_reg;
      s_mem_reg <= s_ix_reg;
      s_ix_reg  <= bubble ? SHADOW_BUBBLE : dec_entry;
    end
  end

  assign s_ix  = s_ix_reg;
  assign s_mem = s_mem_reg;
  assign s_wb  = s_wb_reg;

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall, forwarding select and branch flush sequencing for ID/IX.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_is_store,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_write_to_reg,
  input  logic                  id_is_load,
  input  logic                  ix_branch_taken,
  output logic                  stall_out,
  output logic                  flush_out,
  output logic                  mx_op1_bypass,
  output logic                  mx_op2_bypass,
  output logic                  wx_op1_bypass,
  output logic                  wx_op2_bypass,
  output logic                  wm_data_bypass
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
`endif
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);

  hcu_state_t      state_reg, state_next;
  logic [FC_W-1:0] cnt_reg, cnt_next;

  shadow_entry_t dec_entry, s_ix, s_mem, s_wb;
  logic          hazard, active;
  logic          rt_is_operand;
  logic          wb_slot_unused;

  assign dec_entry = '{valid: id_valid, dest: id_dest, wr: id_write_to_reg,
                       is_load: id_is_load};

  hazard_shadow_pipe u_shadow (
    .clk       (clk),
    .rst       (rst),
    .bubble    (stall_out | flush_out),
    .dec_entry (dec_entry),
    .s_ix      (s_ix),
    .s_mem     (s_mem),
    .s_wb      (s_wb)
  );

  // WB results reach decode through the register file, not via a bypass here.
  assign wb_slot_unused = ^s_wb;

  assign rt_is_operand = id_uses_rt & ~id_is_store;

  assign hazard = s_ix.is_load &
                  ((id_uses_rs & entry_matches(s_ix, id_rs)) |
                   (rt_is_operand & entry_matches(s_ix, id_rt)));

  assign flush_out = ix_branch_taken | (state_reg == FLUSH);
  assign stall_out = hazard & id_valid & ~flush_out;

  // Bypass selects only apply to a live instruction that is neither squashed nor stalled.
  assign active = id_valid & ~flush_out & ~hazard;

  assign mx_op1_bypass  = active & id_uses_rs & entry_matches(s_ix, id_rs);
  assign mx_op2_bypass  = active & rt_is_operand & entry_matches(s_ix, id_rt);
  assign wx_op1_bypass  = active & id_uses_rs & entry_matches(s_mem, id_rs) & ~mx_op1_bypass;
  assign wx_op2_bypass  = active & rt_is_operand & entry_matches(s_mem, id_rt) & ~mx_op2_bypass;
  assign wm_data_bypass = active & id_is_store & id_uses_rt & s_ix.is_load &
                          entry_matches(s_ix, id_rt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN:   if (stall_out) state_next = STALL;
      STALL: state_next = RUN;
      FLUSH: begin
        if (cnt_reg <= FC_W'(1)) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - FC_W'(1);
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
    // A taken branch (re)starts the flush window from any state.
    if (ix_branch_taken) begin
      if (FLUSH_CYCLES > 1) begin
        state_next = FLUSH;
        cnt_next   = FC_RELOAD;
      end else begin
        state_next = RUN;
        cnt_next   = '0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic             branch_prev_reg;
  logic [CNT_W-1:0] stall_count_reg, flush_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_prev_reg <= 1'b0;
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      branch_prev_reg <= ix_branch_taken;
      if (stall_out && (stall_count_reg != '1))
        stall_count_reg <= stall_count_reg + CNT_W'(1);
      if (ix_branch_taken && !branch_prev_reg && (state_reg != STALL) &&
          (flush_count_reg != '1))
        flush_count_reg <= flush_count_reg + CNT_W'(1);
    end
  end

  assign stall_count = stall_count_reg;
  assign flush_count = flush_count_reg;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit; output vector order is
// {stall, flush, mx1, mx2, wx1, wx2, wm}.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_is_store, id_write_to_reg, id_is_load;
  logic       ix_branch_taken;
  logic       stall_out, flush_out;
  logic       mx_op1_bypass, mx_op2_bypass, wx_op1_bypass, wx_op2_bypass, wm_data_bypass;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;
`endif
  logic [6:0] outs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_control_unit dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_is_store     (id_is_store),
    .id_dest         (id_dest),
    .id_write_to_reg (id_write_to_reg),
    .id_is_load      (id_is_load),
    .ix_branch_taken (ix_branch_taken),
    .stall_out       (stall_out),
    .flush_out       (flush_out),
    .mx_op1_bypass   (mx_op1_bypass),
    .mx_op2_bypass   (mx_op2_bypass),
    .wx_op1_bypass   (wx_op1_bypass),
    .wx_op2_bypass   (wx_op2_bypass),
    .wm_data_bypass  (wm_data_bypass)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_count     (stall_count),
    .flush_count     (flush_count)
`endif
  );

  assign outs = {stall_out, flush_out, mx_op1_bypass, mx_op2_bypass,
                 wx_op1_bypass, wx_op2_bypass, wm_data_bypass};

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end else begin
      $display("ok   %s outs=%b", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_check(input string tag, input logic [6:0] exp);
    #2;
    check_eq(tag, outs, exp);
  endtask

  task automatic drive_idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_is_store = 0; id_dest = 0; id_write_to_reg = 0; id_is_load = 0;
  endtask

  task automatic drive_instr(input logic [4:0] rs, input logic [4:0] rt,
                             input logic urs, input logic urt, input logic st,
                             input logic [4:0] dest, input logic wr, input logic ld);
    id_valid = 1; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_is_store = st; id_dest = dest; id_write_to_reg = wr; id_is_load = ld;
  endtask

  task automatic drain();
    drive_idle();
    repeat (3) tick();
  endtask

  initial begin
    rst = 1; ix_branch_taken = 0;
    drive_idle();
    tick(); tick();
    settle_check("reset_outs", 7'b0000000);
    rst = 0;
    tick();

    // load $5 ; add $6,$5,$7
    drive_instr(5'd0, 5'd0, 1, 0, 0, 5'd5, 1, 1);
    settle_check("lu_load", 7'b0000000);
    tick();
    drive_instr(5'd5, 5'd7, 1, 1, 0, 5'd6, 1, 0);
    settle_check("lu_stall", 7'b1000000);
    tick();
    settle_check("lu_after_wx1", 7'b0000100);
    drain();

    // add $3,$1,$2 ; sub $4,$3,$3
    drive_instr(5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0);
    settle_check("mx_prod", 7'b0000000);
    tick();
    drive_instr(5'd3, 5'd3, 1, 1, 0, 5'd4, 1, 0);
    settle_check("mx_both", 7'b0011000);
    drain();

    // two producers of $3 ahead of a consumer: MX wins
    drive_instr(5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0);
    tick();
    drive_instr(5'd4, 5'd5, 1, 1, 0, 5'd3, 1, 0);
    settle_check("prio_mid", 7'b0000000);
    tick();
    drive_instr(5'd3, 5'd6, 1, 1, 0, 5'd7, 1, 0);
    settle_check("prio_mx_over_wx", 7'b0010000);
    drain();

    // wx on op2 alone: producer two ahead of consumer reading rt
    drive_instr(5'd1, 5'd2, 1, 1, 0, 5'd10, 1, 0);
    tick();
    drive_idle();
    tick();
    drive_instr(5'd11, 5'd10, 1, 1, 0, 5'd12, 1, 0);
    settle_check("wx_op2", 7'b0000010);
    drain();

    // load $8 ; sw $8,0($9)
    drive_instr(5'd0, 5'd0, 1, 0, 0, 5'd8, 1, 1);
    tick();
    drive_instr(5'd9, 5'd8, 1, 1, 1, 5'd0, 0, 0);
    settle_check("store_wm", 7'b0000001);
    drain();

    // taken branch while a load-use hazard sits in ID
    drive_instr(5'd0, 5'd0, 1, 0, 0, 5'd5, 1, 1);
    tick();
    drive_instr(5'd5, 5'd7, 1, 1, 0, 5'd6, 1, 0);
    ix_branch_taken = 1;
    settle_check("flush_c0", 7'b0100000);
    tick();
    ix_branch_taken = 0;
    settle_check("flush_c1", 7'b0100000);
    tick();
    settle_check("flush_done", 7'b0000000);
    drain();

    // second branch during FLUSH reloads the counter
    ix_branch_taken = 1;
    settle_check("reload_c0", 7'b0100000);
    tick();
    settle_check("reload_c1", 7'b0100000);
    tick();
    ix_branch_taken = 0;
    settle_check("reload_c2", 7'b0100000);
    tick();
    settle_check("reload_done", 7'b0000000);
    drain();

    // $0 as load destination then read back twice
    drive_instr(5'd0, 5'd0, 1, 0, 0, 5'd0, 1, 1);
    tick();
    drive_instr(5'd0, 5'd0, 1, 1, 0, 5'd2, 1, 0);
    settle_check("zero_ix", 7'b0000000);
    tick();
    settle_check("zero_mem", 7'b0000000);
    drain();

    // reset in the middle of a flush
    ix_branch_taken = 1;
    tick();
    ix_branch_taken = 0;
    settle_check("rst_flush_pre", 7'b0100000);
    rst = 1;
    tick();
    settle_check("rst_flush_post", 7'b0000000);
    rst = 0;
    drain();

    // reset in the middle of a stall clears the load from the shadow
    drive_instr(5'd0, 5'd0, 1, 0, 0, 5'd5, 1, 1);
    tick();
    drive_instr(5'd5, 5'd7, 1, 1, 0, 5'd6, 1, 0);
    settle_check("rst_stall_pre", 7'b1000000);
    rst = 1;
    tick();
    settle_check("rst_stall_post", 7'b0000000);
    rst = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Producer side of the ID/IX register control inputs. Drives stall, flush and the five bypass-select bits that the ID/IX register latches.
- Keeps its own shadow pipeline of in-flight destination registers for the IX, MEM and WB stages, so it needs no back-feed from later stages.
- Detects load-use hazards, resolves forwarding paths, and sequences flushes after a taken branch.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- FLUSH_CYCLES, 2, total cycles flush_out is held per taken branch (minimum 1).
- CNT_W, 32, performance-counter width (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs  in  REG_ADDR_W  decode source 1
- id_rt  in  REG_ADDR_W  decode source 2
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_is_store  in  1  rt is store data, not an ALU operand
- id_dest  in  REG_ADDR_W  resolved destination register
- id_write_to_reg  in  1  instruction writes id_dest
- id_is_load  in  1  instruction is a load
- ix_branch_taken  in  1  branch or jump in IX redirects fetch
- stall_out  out  1  hold IF/ID; insert a bubble into ID/IX
- flush_out  out  1  squash IF/ID and ID/IX
- mx_op1_bypass  out  1  forward MEM result to operand 1
- mx_op2_bypass  out  1  forward MEM result to operand 2
- wx_op1_bypass  out  1  forward WB result to operand 1
- wx_op2_bypass  out  1  forward WB result to operand 2
- wm_data_bypass  out  1  forward WB load data to store data in MEM
- stall_count  out  CNT_W  (only with HAZARD_PERF_CNT_EN)
- flush_count  out  CNT_W  (only with HAZARD_PERF_CNT_EN)

Behaviour:
- Shadow entry: {valid, dest, wr, is_load}. There are three slots: S_IX, S_MEM and S_WB.
- Each clock: S_WB <= S_MEM and S_MEM <= S_IX.
- S_IX update each clock:
  - flush_out=1: S_IX <= bubble.
  - else stall_out=1: S_IX <= bubble.
  - else: S_IX <= decode entry, with valid=id_valid.
- Match rule: "X matches r" means X.valid & X.wr & X.dest==r & r!=0. Register 0 never matches.
- Load-use: hazard = S_IX.is_load & ((uses_rs & match rs) | (uses_rt & !is_store & match rt)).
- stall_out = hazard & id_valid & !flush_out. This is combinational, with no added latency.
- Store-data path: a store whose rt matches S_IX (a load) does not stall. It sets wm_data_bypass=1 instead.
- Bypass bits are combinational and computed against the stage each producer will occupy when the consumer reaches IX:
  - mx_opN = uses_N & S_IX matches src_N & !hazard.
  - wx_opN = uses_N & S_MEM matches src_N & !mx_opN. MX has priority.
  - For stores, op2 bypasses are suppressed; wx/wm handles the data instead.
- All bypass outputs are 0 when id_valid=0 or flush_out=1.
- FSM states: RUN, STALL, FLUSH.
  - RUN to STALL: stall_out=1. STALL lasts exactly one cycle, then the state returns to RUN. During that cycle the load sits in S_MEM, so a repeat stall cannot occur and the consumer gets wx.
  - Any state to FLUSH: ix_branch_taken=1. flush_out is asserted combinationally in that cycle and then for FLUSH_CYCLES-1 further cycles, timed by a down-counter.
  - FLUSH to RUN: counter reaches 0.
  - A new ix_branch_taken during FLUSH reloads the counter.
- Simultaneous events: flush beats stall, and stall beats bypass.
- Reset: all shadow slots invalid, state RUN, counter 0. All outputs read 0 in the cycle after rst is sampled high. Reset mid-flush or mid-stall aborts immediately.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_count increments on each cycle with stall_out=1.
  - flush_count increments on each rising edge of ix_branch_taken accepted in RUN or FLUSH.
  - Both counters saturate at all-ones and clear on rst.
- Undefined: the ports and the counters are absent.

Decomposition:
- Shared package: REG_ADDR_W, the FSM state encoding (RUN=0, STALL=1, FLUSH=2), the shadow-entry struct/typedef, and the REG_ZERO constant.
- One natural sub-module: hazard_shadow_pipe, which holds the three-slot shadow register with bubble-insert and flush controls.
- Bypass and FSM logic stay in the top module.

Test Plan:
- Load $5 then add $6,$5,$7 → stall_out=1 for exactly 1 cycle; next cycle wx_op1_bypass=1, mx=0.
- add $3,$1,$2 then sub $4,$3,$3 → mx_op1_bypass=1 and mx_op2_bypass=1, no stall.
- Producer to $3 two ahead of a consumer that also has a $3 producer one ahead → mx=1, wx=0 (priority).
- Load $8 then sw $8,0($9) → stall_out=0, wm_data_bypass=1.
- ix_branch_taken pulse with FLUSH_CYCLES=2, while a load-use hazard is present in ID → flush_out high for 2 cycles, stall_out=0, all bypass bits 0.
- Writes to $0 followed by reads of $0 → no stall and no bypass. rst asserted mid-FLUSH → flush_out=0 on the next cycle.
